// File: rtl/signed_integrator.sv
// signed_integrator: integrate-and-dump accumulator for signed fixed-point samples.
// Sums max(acc_len,1) valid samples per frame into a DIN_WIDTH+ACC_LEN_WIDTH word
// (binary point unchanged) and emits it with a one-cycle strobe.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        signed input sample (DIN_WIDTH.DIN_POINT)
//   din_valid  din qualifier
//   sync       single-cycle frame restart pulse
//   acc_len    samples per frame, 0 treated as 1, sampled at frame boundaries and sync
//   dout       signed frame sum (DOUT_WIDTH.DOUT_POINT), holds between strobes
//   dout_valid one-cycle strobe, dout valid
//   frame_drop one-cycle strobe, a partial frame was aborted by sync
module signed_integrator #(
    parameter int DIN_WIDTH     = 16,
    parameter int DIN_POINT     = 15,
    parameter int ACC_LEN_WIDTH = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DIN_WIDTH-1:0]               din,
    input  logic                               din_valid,
    input  logic                               sync,
    input  logic [ACC_LEN_WIDTH-1:0]           acc_len,
    output logic [DIN_WIDTH+ACC_LEN_WIDTH-1:0] dout,
    output logic                               dout_valid,
    output logic                               frame_drop
);
    localparam int DOUT_WIDTH = DIN_WIDTH + ACC_LEN_WIDTH;
    localparam int DOUT_POINT = DIN_POINT;
    localparam logic [0:0] WAIT_SYNC = 1'b0;
    localparam logic [0:0] RUN       = 1'b1;

    if (DOUT_POINT > DOUT_WIDTH) begin : g_point_check
        $error("signed_integrator: binary point exceeds output width");
    end

    logic [0:0]               r_state;
    logic [DOUT_WIDTH-1:0]    r_acc;
    logic [ACC_LEN_WIDTH-1:0] r_count;
    logic [ACC_LEN_WIDTH-1:0] r_len;
    logic [DOUT_WIDTH-1:0]    r_dout;
    logic                     r_dout_valid;
    logic                     r_frame_drop;

    logic [DOUT_WIDTH-1:0]    w_din_ext;
    logic [ACC_LEN_WIDTH-1:0] w_len_new;
    logic                     w_run;
    logic [DOUT_WIDTH-1:0]    w_base_acc;
    logic [ACC_LEN_WIDTH-1:0] w_base_cnt;
    logic [ACC_LEN_WIDTH-1:0] w_len;
    logic                     w_take;
    logic [DOUT_WIDTH-1:0]    w_sum;
    logic [ACC_LEN_WIDTH-1:0] w_cnt_inc;
    logic                     w_last;

    // sync restarts the frame in the same cycle, so a sample arriving with it
    // is accumulated onto a cleared frame measured against the freshly loaded length.
    always_comb begin
        w_din_ext  = {{ACC_LEN_WIDTH{din[DIN_WIDTH-1]}}, din};
        w_len_new  = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
        w_run      = (r_state == RUN);
        w_base_acc = sync ? '0 : r_acc;
        w_base_cnt = sync ? '0 : r_count;
        w_len      = sync ? w_len_new : r_len;
        w_take     = din_valid && (sync || w_run);
        w_sum      = w_base_acc + w_din_ext;
        w_cnt_inc  = w_base_cnt + ACC_LEN_WIDTH'(1);
        w_last     = w_take && (w_cnt_inc == w_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_SYNC;
            r_acc        <= '0;
            r_count      <= '0;
            r_len        <= ACC_LEN_WIDTH'(1);
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_state      <= sync ? RUN : r_state;
            r_acc        <= w_last ? '0 : (w_take ? w_sum : w_base_acc);
            r_count      <= w_last ? '0 : (w_take ? w_cnt_inc : w_base_cnt);
            r_len        <= (sync || w_last) ? w_len_new : r_len;
            r_dout       <= w_last ? w_sum : r_dout;
            r_dout_valid <= w_last;
            r_frame_drop <= sync && w_run && (r_count != '0);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_drop = r_frame_drop;
endmodule

// File: tb/tb_signed_integrator.sv
// tb_signed_integrator: directed plus randomized check of signed_integrator against a sample-queue model.
module tb_signed_integrator;
    localparam int DW = 16;
    localparam int LW = 10;
    localparam int OW = DW + LW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          sync = 1'b0;
    logic [LW-1:0] acc_len = '0;
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          frame_drop;

    int total = 0;
    int bad = 0;

    // reference model: the samples of the open frame are kept verbatim
    bit     m_run = 1'b0;
    int     m_q[$];
    int     m_len = 1;
    longint m_dout = 0;
    bit     m_valid = 1'b0;
    bit     m_drop = 1'b0;

    signed_integrator dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
        .acc_len(acc_len), .dout(dout), .dout_valid(dout_valid), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_q.delete();
        m_len = 1;
        m_dout = 0;
        m_valid = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_edge();
        longint s;
        m_valid = 1'b0;
        m_drop = 1'b0;
        if (sync) begin
            m_drop = m_run && (m_q.size() > 0);
            m_q.delete();
            m_len = (acc_len == 0) ? 1 : int'(acc_len);
            m_run = 1'b1;
        end
        if (m_run && din_valid) begin
            m_q.push_back(int'($signed(din)));
            if (m_q.size() == m_len) begin
                s = 0;
                foreach (m_q[i]) s += m_q[i];
                m_dout = s;
                m_valid = 1'b1;
                m_q.delete();
                m_len = (acc_len == 0) ? 1 : int'(acc_len);
            end
        end
    endtask

    // one clock: drive at negedge, model at posedge, sample 1 time unit later
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit s, input logic [LW-1:0] l);
        din_valid = v;
        din = d;
        sync = s;
        acc_len = l;
        @(posedge clk);
        model_edge();
        #1;
        check("dout_valid", {63'b0, dout_valid}, {63'b0, m_valid});
        check("frame_drop", {63'b0, frame_drop}, {63'b0, m_drop});
        check("dout", 64'($signed(dout)), 64'(m_dout));
        @(negedge clk);
    endtask

    initial begin
        #2;
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_dout_valid", {63'b0, dout_valid}, 64'(0));
        check("rst_frame_drop", {63'b0, frame_drop}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        // test 1: a completed frame leaves dout nonzero, then reset mid-frame
        cyc(0, 16'h0000, 1, 10'd1);
        cyc(1, 16'h4000, 0, 10'd4);
        check("len1_dout", 64'($signed(dout)), 64'(16'sh4000));
        cyc(0, 16'h0000, 1, 10'd4);
        cyc(1, 16'h4000, 0, 10'd4);
        cyc(1, 16'h4000, 0, 10'd4);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_dout", 64'(dout), 64'(0));
        check("async_dout_valid", {63'b0, dout_valid}, 64'(0));
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) cyc(1, 16'h4000, 0, 10'd1);
        // test 2: basic dump followed immediately by a second frame
        cyc(0, 16'h0000, 1, 10'd4);
        cyc(1, 16'h4000, 0, 10'd4);
        cyc(1, 16'h4000, 0, 10'd4);
        cyc(1, 16'hC000, 0, 10'd4);
        cyc(1, 16'h2000, 0, 10'd4);
        check("basic_dout", 64'($signed(dout)), 64'(26'sh0006000));
        for (int i = 0; i < 4; i++) cyc(1, 16'h1000, 0, 10'd4);
        check("second_dout", 64'($signed(dout)), 64'(26'sh0004000));
        // test 3: full-scale negative, gapped, maximum length
        cyc(0, 16'h0000, 1, 10'd1023);
        for (int i = 0; i < 1023; i++) begin
            cyc(1, 16'h8000, 0, 10'd1023);
            cyc(0, 16'h8000, 0, 10'd1023);
        end
        check("fullscale_dout", 64'($signed(dout)), -64'(1023 * 32768));
        // test 4: sync abort with a sample on the sync cycle
        cyc(0, 16'h0000, 1, 10'd8);
        for (int i = 0; i < 3; i++) cyc(1, 16'h0100, 0, 10'd8);
        cyc(1, 16'h0200, 1, 10'd8);
        for (int i = 0; i < 8; i++) cyc(1, 16'h0300, 0, 10'd8);
        // test 5: acc_len change mid-frame, then zero length
        cyc(0, 16'h0000, 1, 10'd4);
        cyc(1, 16'h0010, 0, 10'd4);
        for (int i = 0; i < 5; i++) cyc(1, 16'h0020, 0, 10'd2);
        cyc(0, 16'h0000, 1, 10'd0);
        for (int i = 0; i < 4; i++) cyc(1, 16'hFFF0 + 16'(i), 0, 10'd0);
        // test 6: sync colliding with the last sample
        cyc(0, 16'h0000, 1, 10'd2);
        cyc(1, 16'h0040, 0, 10'd2);
        cyc(1, 16'h0050, 1, 10'd2);
        cyc(1, 16'h0060, 0, 10'd2);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 9) < 6,
                16'($urandom),
                $urandom_range(0, 39) == 0,
                ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 5)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
